// File: rtl/approx_pkg.sv
// Shared widths and FSM state encoding for the approximate MAC accumulator.
package approx_pkg;
  localparam int PROD_W = 8;
  localparam int ACC_W  = 16;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/approx_sat_add.sv
// Unsigned saturating adder; purely combinational, no backpressure.
// sat flags that the true sum did not fit and sum was clamped to all-ones.
module approx_sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);
  logic [W:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    sat = raw[W];
    sum = raw[W] ? '1 : raw[W-1:0];
  end
endmodule

// File: rtl/approx_mac_accum.sv
// Burst accumulator of multiplier products: one product/cycle in ACCUM, result 1 cycle after last transfer.
// Products are taken only while ACCUM; the result is held in DONE until sum_ready_i.
module approx_mac_accum
  import approx_pkg::*;
#(
  parameter int PROD_W = approx_pkg::PROD_W,
  parameter int ACC_W  = approx_pkg::ACC_W,
  parameter int LEN_W  = approx_pkg::LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              prod_valid_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic              prod_ready_o,
  output logic              sum_valid_o,
  input  logic              sum_ready_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              overflow_o,
  output logic              busy_o
);
  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   add_sum;
  logic               add_sat;

  approx_sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc_q),
    .b   (ACC_W'(prod_i)),
    .sum (add_sum),
    .sat (add_sat)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = len_i;
          state_d = (len_i == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (prod_valid_i) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_sat;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        // start_i is deliberately not looked at here, even on the handshake edge
        if (sum_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign prod_ready_o = (state_q == ACCUM);
  assign sum_valid_o  = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign sum_o        = acc_q;
  assign overflow_o   = ovf_q;
endmodule

// File: doc/approx_mac_accum.md
APPROX_MAC_ACCUM -- requirements
Module: approx_mac_accum

Interface
REQ-001 SHALL have parameter PROD_W, default 8, width of the incoming product from approx_multiplier_4x4.
REQ-002 SHALL have parameter ACC_W, default 16, accumulator and result width; ACC_W >= PROD_W.
REQ-003 SHALL have parameter LEN_W, default 8, width of the burst-length field.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset, asynchronous assert, active-low.
REQ-006 SHALL have port start_i, input, 1, begin a burst; sampled only in IDLE.
REQ-007 SHALL have port len_i, input, LEN_W, number of products in the burst; captured with start_i.
REQ-008 SHALL have port prod_valid_i, input, 1, prod_i holds a valid product.
REQ-009 SHALL have port prod_i, input, PROD_W, unsigned product from the multiplier stage.
REQ-010 SHALL have port prod_ready_o, output, 1, block accepts a product this cycle.
REQ-011 SHALL have port sum_valid_o, output, 1, sum_o and overflow_o are valid.
REQ-012 SHALL have port sum_ready_i, input, 1, consumer accepts the result.
REQ-013 SHALL have port sum_o, output, ACC_W, accumulated unsigned sum, registered.
REQ-014 SHALL have port overflow_o, output, 1, sticky flag: saturation occurred during this burst.
REQ-015 SHALL have port busy_o, output, 1, high in any state other than IDLE.

Function
REQ-016 SHALL implement an FSM with states IDLE, ACCUM, DONE.
REQ-017 IDLE: start_i=1 with len_i>0 -> ACCUM; clear accumulator and overflow; load remaining count with len_i.
REQ-018 IDLE: start_i=1 with len_i=0 -> DONE directly; sum_o=0, overflow_o=0.
REQ-019 prod_ready_o SHALL be 1 only in ACCUM; a product transfers when prod_valid_i && prod_ready_o.
REQ-020 On each transfer, the accumulator SHALL become the saturating sum acc + zero-extended prod_i, and the remaining count SHALL decrement by 1.
REQ-021 If the true sum exceeds 2^ACC_W-1, the accumulator SHALL hold 2^ACC_W-1 and overflow SHALL set; it stays set until the next burst start.
REQ-022 A transfer that brings the remaining count to 0 SHALL move the FSM to DONE on the same edge; sum_valid_o is asserted the following cycle.
REQ-023 ACCUM with prod_valid_i=0 SHALL hold all state; no timeout applies.
REQ-024 DONE: sum_valid_o=1; sum_o and overflow_o SHALL stay stable until sum_ready_i=1, then the FSM returns to IDLE on that edge.
REQ-025 start_i SHALL be ignored in ACCUM and DONE, including in the DONE handshake cycle; a new burst needs start_i in IDLE.
REQ-026 Throughput SHALL be one product per cycle in ACCUM; minimum burst overhead is 1 start cycle plus 1 result handshake cycle.
REQ-027 prod_i SHALL be ignored whenever prod_ready_o=0.

Reset
REQ-028 rst_ni=0 SHALL force IDLE, accumulator=0, count=0, overflow=0 asynchronously.
REQ-029 Reset SHALL force sum_valid_o=0, prod_ready_o=0, busy_o=0, sum_o=0, overflow_o=0 asynchronously.
REQ-030 Reset mid-burst SHALL discard the partial sum; no result is emitted for that burst.
REQ-031 Deassertion SHALL take effect at the next rising clk_i edge; the first start_i is accepted then at the earliest.

Structure
REQ-032 A shared package approx_pkg SHALL hold the FSM state enum (IDLE, ACCUM, DONE) and the default width constants PROD_W, ACC_W, LEN_W.
REQ-033 The saturating add SHALL be a separate combinational sub-module approx_sat_add (inputs a, b; outputs sum, sat).
REQ-034 All outputs SHALL be driven from registers or the state decode; no combinational path from prod_i to sum_o.

Verification
REQ-035 len=4, products 225,225,225,225 back-to-back -> sum_o=900 (0x0384), overflow_o=0, sum_valid_o 1 cycle after the 4th transfer.
REQ-036 len=3, prod_valid_i toggling 1,0,0,1,0,1 with products 10,20,30 -> sum_o=60; count decrements only on transfers.
REQ-037 ACC_W=10, len=5, products 225 each -> sum_o=1023, overflow_o=1; next burst len=1 with product 7 -> sum_o=7, overflow_o=0.
REQ-038 len=0 start -> DONE next cycle with sum_o=0; sum_ready_i held 0 for 3 cycles -> outputs stable; sum_ready_i=1 -> IDLE.
REQ-039 rst_ni pulsed low after 2 of 4 products -> all outputs 0 immediately; a fresh burst len=2 with products 1,2 -> sum_o=3.
REQ-040 start_i asserted during ACCUM and during the DONE handshake cycle -> ignored; len and sum unchanged.
